fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline, directly upstream of the decoder and register file.
- Owns the PC register and drives the word address to the combinational instruction memory.
- Latches the returned instruction into the IF/ID pipeline register consumed by decode.
- Handles decode-stall hold, branch/jump redirect with wrong-path squash, halt on ECALL/EBREAK, and a misaligned-target fault.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID when not valid.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  synchronous, active-high reset.
imem_addr  output  32  fetch address, equals pc_q (combinational).
imem_instr  input  32  instruction word at imem_addr, same cycle (async ROM).
stall  input  1  decode hazard; hold PC and IF/ID.
redirect_valid  input  1  taken branch/JAL/JALR from later stage.
redirect_target  input  32  new PC for redirect.
if_id_instr  output  32  latched instruction to decoder.
if_id_pc  output  32  PC of if_id_instr.
if_id_pc_plus4  output  32  if_id_pc + 4 (for JAL/JALR link, AUIPC base).
if_id_valid  output  1  IF/ID holds a real instruction.
halted  output  1  fetch stopped after ECALL/EBREAK.
fault  output  1  sticky misaligned-redirect fault.
fault_addr  output  32  offending redirect_target.
fetch_count  output  32  number of instructions latched valid into IF/ID.

Behaviour:
- Reset (any cycle, including mid-operation): pc_q=RESET_VECTOR, state=RUN, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, halted=0, fault=0, fault_addr=0, fetch_count=0.
- The first instruction appears in IF/ID on the first rising edge after reset deasserts, giving 1-cycle fetch latency.
- States: RUN, HALTED, FAULT. halted=(state==HALTED); fault=(state==FAULT).
- Priority each edge: reset > redirect_valid > stall > normal advance.
- RUN, normal advance (no stall, no redirect):
  - IF/ID <= {imem_instr, pc_q, pc_q+4, valid=1}.
  - pc_q <= pc_q+4, with 32-bit wrap-around: 32'hFFFF_FFFC advances to 0.
  - fetch_count += 1, wrapping.
- RUN, stall=1 with no redirect: pc_q, all IF/ID fields and fetch_count hold their values.
- redirect_valid=1, aligned target (target[1:0]==0), in RUN or HALTED:
  - pc_q <= redirect_target.
  - IF/ID <= bubble (NOP_INSTR, valid=0; pc fields hold) to squash the wrong-path instruction fetched this cycle.
  - state <= RUN. Redirect overrides a simultaneous stall.
  - fetch_count unchanged.
- redirect_valid=1, misaligned target (target[1:0]!=0):
  - state <= FAULT, fault_addr <= redirect_target, IF/ID <= bubble, pc_q holds.
- Halt detect, in RUN with no stall and no redirect, when imem_instr==32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK):
  - The instruction is latched valid and counted as normal.
  - pc_q <= pc_q+4, state <= HALTED.
- HALTED:
  - pc_q holds. Each non-stalled cycle IF/ID <= bubble.
  - Stall still holds IF/ID, so a stalled ECALL stays visible to decode.
  - Exits only on reset or aligned redirect.
- FAULT: pc_q holds; IF/ID bubble each cycle; ignores stall and redirect; exits only on reset.
- imem_addr is always pc_q, including while stalled, halted or faulted.

Decomposition:
- Shared package rv32_pkg holds: NOP_INSTR, ECALL/EBREAK encodings, the fetch state enum {RUN, HALTED, FAULT}, and XLEN=32.
- One natural sub-module, if_id_reg: the IF/ID register with load, hold and bubble controls, reused by later pipeline registers.
- PC update and state logic stay in fetch_stage.

Test Plan:
- Reset release, ROM words 0x00500093, 0x00A00113, 0x002081B3 at 0x0/0x4/0x8, no stall -> IF/ID shows (0x00500093,pc 0x0,pc+4 0x4) edge 1, (0x00A00113,0x4,0x8) edge 2, (0x002081B3,0x8,0xC) edge 3; fetch_count=3.
- stall held 3 cycles while IF/ID holds pc 0x4 -> IF/ID and imem_addr=0x8 unchanged for 3 edges, fetch_count constant; release -> pc 0x8 latched next edge.
- redirect_valid=1, target 0x40, stall=1 same cycle -> next edge if_id_valid=0, if_id_instr=0x00000013, imem_addr=0x40; following edge IF/ID pc=0x40, valid=1.
- ROM word 0x00100073 at 0xC -> IF/ID holds it valid with pc 0xC, halted=1; next 5 edges if_id_valid=0, imem_addr=0x10; redirect to 0x0 -> halted=0, fetch resumes at 0x0.
- redirect target 0x42 -> fault=1, fault_addr=0x42, if_id_valid=0 permanently; later aligned redirect to 0x0 ignored; reset clears fault and pc=RESET_VECTOR.
- Reset asserted mid-run at pc 0x20 with stall=1 -> next edge pc_q=0, if_id_valid=0, fetch_count=0, if_id_instr=0x00000013.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: data width, special instruction encodings
// and the fetch-stage state enumeration.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] ECALL_INSTR  = 32'h0000_0073;
  localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_t;

  // True when the word is one of the instructions that stop fetch.
  function automatic logic is_halt_instr(input logic [XLEN-1:0] word);
    return (word == ECALL_INSTR) || (word == EBREAK_INSTR);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register with load, hold and bubble controls.
// A bubble replaces the instruction with a NOP and clears valid while
// leaving the PC fields untouched; bubble wins over load.
module if_id_reg
  import rv32_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc,
  input  logic [31:0] next_pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Register update: reset, then bubble, then load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr    <= NOP;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (bubble) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (load) begin
      instr    <= next_instr;
      pc       <= next_pc;
      pc_plus4 <= next_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, addresses the async
// instruction ROM and feeds the IF/ID register. Handles decode stalls,
// redirects with wrong-path squash, halting on ECALL/EBREAK and a sticky
// fault on misaligned redirect targets.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = rv32_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);
  import rv32_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] count_q, count_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic            load, bubble;
  logic            target_aligned;

  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = (redirect_target[1:0] == 2'b00);

  // Next-state, next-PC and IF/ID control selection by priority.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    fault_addr_d = fault_addr_q;
    load         = 1'b0;
    bubble       = 1'b0;
    case (state_q)
      RUN, HALTED: begin
        if (redirect_valid) begin
          bubble = 1'b1;
          if (target_aligned) begin
            pc_d    = redirect_target;
            state_d = RUN;
          end else begin
            fault_addr_d = redirect_target;
            state_d      = FAULT;
          end
        end else if (stall) begin
          load = 1'b0;
        end else if (state_q == RUN) begin
          load    = 1'b1;
          pc_d    = pc_plus4;
          count_d = count_q + 32'd1;
          if (is_halt_instr(imem_instr)) begin
            state_d = HALTED;
          end
        end else begin
          bubble = 1'b1;
        end
      end
      default: begin
        bubble = 1'b1;
      end
    endcase
  end

  // State, PC, counter and fault address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      count_q      <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  if_id_reg #(
    .NOP(NOP_INSTR)
  ) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .bubble       (bubble),
    .next_instr   (imem_instr),
    .next_pc      (pc_q),
    .next_pc_plus4(pc_plus4),
    .instr        (if_id_instr),
    .pc           (if_id_pc),
    .pc_plus4     (if_id_pc_plus4),
    .valid        (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == HALTED);
  assign fault       = (state_q == FAULT);
  assign fault_addr  = fault_addr_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a small combinational ROM.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  logic [31:0] rom [0:63];
  int checks;
  int failures;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fault          (fault),
    .fault_addr     (fault_addr),
    .fetch_count    (fetch_count)
  );

  assign imem_instr = rom[imem_addr[7:2]];

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs, then advance one rising edge and settle.
  task automatic applyStimulus(input logic rst, input logic stl,
                               input logic rv, input logic [31:0] tgt);
    reset           = rst;
    stall           = stl;
    redirect_valid  = rv;
    redirect_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIfId(input string tag, input logic [31:0] ins,
                           input logic [31:0] pc, input logic [31:0] pc4,
                           input logic vld);
    checkOutput({tag, ".instr"}, if_id_instr, ins);
    checkOutput({tag, ".pc"}, if_id_pc, pc);
    checkOutput({tag, ".pc4"}, if_id_pc_plus4, pc4);
    checkOutput({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, vld});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) rom[i] = NOP;
    rom[0]  = 32'h0050_0093;
    rom[1]  = 32'h00A0_0113;
    rom[2]  = 32'h0020_81B3;
    rom[3]  = 32'h0010_0073;
    rom[16] = 32'h0030_8233;
    rom[17] = 32'h0000_0073;
    rom[63] = 32'h0040_0193;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkIfId("rst", NOP, 32'h0, 32'h0, 1'b0);
    checkOutput("rst.addr", imem_addr, 32'h0);
    checkOutput("rst.count", fetch_count, 32'h0);
    checkOutput("rst.halted", {31'b0, halted}, 32'h0);
    checkOutput("rst.fault", {31'b0, fault}, 32'h0);
    checkOutput("rst.faddr", fault_addr, 32'h0);

    // Sequential fetch
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkIfId("e1", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
    checkOutput("e1.count", fetch_count, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkIfId("e2", 32'h00A0_0113, 32'h4, 32'h8, 1'b1);
    checkOutput("e2.addr", imem_addr, 32'h8);

    // Stall holds for three edges
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkIfId("stall", 32'h00A0_0113, 32'h4, 32'h8, 1'b1);
      checkOutput("stall.addr", imem_addr, 32'h8);
      checkOutput("stall.count", fetch_count, 32'd2);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkIfId("e3", 32'h0020_81B3, 32'h8, 32'hC, 1'b1);
    checkOutput("e3.count", fetch_count, 32'd3);

    // Redirect overrides stall
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
    checkIfId("redir", NOP, 32'h8, 32'hC, 1'b0);
    checkOutput("redir.addr", imem_addr, 32'h40);
    checkOutput("redir.count", fetch_count, 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkIfId("tgt", 32'h0030_8233, 32'h40, 32'h44, 1'b1);

    // ECALL halts, stall keeps it visible, then bubbles
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkIfId("ecall", 32'h0000_0073, 32'h44, 32'h48, 1'b1);
    checkOutput("ecall.halted", {31'b0, halted}, 32'h1);
    checkOutput("ecall.count", fetch_count, 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkIfId("hstall", 32'h0000_0073, 32'h44, 32'h48, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkIfId("hbub", NOP, 32'h44, 32'h48, 1'b0);
    checkOutput("hbub.addr", imem_addr, 32'h48);
    checkOutput("hbub.count", fetch_count, 32'd5);

    // Redirect out of halt to 0x0, then to 0xC for EBREAK
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("unhalt.halted", {31'b0, halted}, 32'h0);
    checkOutput("unhalt.addr", imem_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkIfId("resume", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
    checkOutput("resume.count", fetch_count, 32'd6);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkIfId("ebreak", 32'h0010_0073, 32'hC, 32'h10, 1'b1);
    checkOutput("ebreak.halted", {31'b0, halted}, 32'h1);
    checkOutput("ebreak.count", fetch_count, 32'd7);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("halt.valid", {31'b0, if_id_valid}, 32'h0);
      checkOutput("halt.addr", imem_addr, 32'h10);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("unhalt2.halted", {31'b0, halted}, 32'h0);
    checkOutput("unhalt2.addr", imem_addr, 32'h0);

    // Misaligned redirect faults; later redirect and stall ignored
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h42);
    checkOutput("flt.fault", {31'b0, fault}, 32'h1);
    checkOutput("flt.faddr", fault_addr, 32'h42);
    checkOutput("flt.addr", imem_addr, 32'h0);
    checkOutput("flt.valid", {31'b0, if_id_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
    checkOutput("flt2.fault", {31'b0, fault}, 32'h1);
    checkOutput("flt2.addr", imem_addr, 32'h0);
    checkOutput("flt2.faddr", fault_addr, 32'h42);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("flt3.valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("flt3.count", fetch_count, 32'd7);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("fltrst.fault", {31'b0, fault}, 32'h0);
    checkOutput("fltrst.faddr", fault_addr, 32'h0);
    checkOutput("fltrst.addr", imem_addr, 32'h0);

    // PC wrap-around at the top of the address space
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkIfId("wrap", 32'h0040_0193, 32'hFFFF_FFFC, 32'h0, 1'b1);
    checkOutput("wrap.addr1", imem_addr, 32'h0);
    checkOutput("wrap.count", fetch_count, 32'd1);

    // Reset mid-run at pc 0x20 with stall asserted
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1C);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("mid.addr", imem_addr, 32'h20);
    checkOutput("mid.count", fetch_count, 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkIfId("midrst", NOP, 32'h0, 32'h0, 1'b0);
    checkOutput("midrst.addr", imem_addr, 32'h0);
    checkOutput("midrst.count", fetch_count, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
